// File: rtl/sevenseg_scan_if.sv
// rtl/sevenseg_scan_if.sv - load/display bundle between core logic and the seven-segment scanner
interface sevenseg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_tick;
  logic                  pending;

  modport master (
    output load, value_in, dp_in,
    input  an, seg, dp, frame_tick, pending
  );

  modport slave (
    input  load, value_in, dp_in,
    output an, seg, dp, frame_tick, pending
  );
endinterface

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - time-multiplexed hex driver with frame-aligned double-buffered load
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module sevenseg_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  sevenseg_scan_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE = PW'(PRESCALE - 1);

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow_val, display_val;
  logic [DIGITS-1:0]   shadow_dp, display_dp;
  logic                pending_r, frame_tick_r;
  logic [DIGITS-1:0]   an_r;
  logic [6:0]          seg_r;
  logic                dp_r;
  logic                step, wrap;
  logic [3:0]          nib;
  logic                dp_sel, blank_sel;
  logic [DIGITS-1:0]   blank;

  function automatic logic [6:0] hex_pattern(input logic [3:0] n);
    case (n)
      4'h0: hex_pattern = 7'h3F;
      4'h1: hex_pattern = 7'h06;
      4'h2: hex_pattern = 7'h5B;
      4'h3: hex_pattern = 7'h4F;
      4'h4: hex_pattern = 7'h66;
      4'h5: hex_pattern = 7'h6D;
      4'h6: hex_pattern = 7'h7D;
      4'h7: hex_pattern = 7'h07;
      4'h8: hex_pattern = 7'h7F;
      4'h9: hex_pattern = 7'h6F;
      4'hA: hex_pattern = 7'h77;
      4'hB: hex_pattern = 7'h7C;
      4'hC: hex_pattern = 7'h39;
      4'hD: hex_pattern = 7'h5E;
      4'hE: hex_pattern = 7'h79;
      default: hex_pattern = 7'h71;
    endcase
  endfunction

  assign step = en && (presc == LAST_PRE);
  assign wrap = step && (idx == LAST_IDX);

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;

  // A digit is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run && (display_val[4*k +: 4] == 4'h0);
      blank[k] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib       = display_val[4*k +: 4];
        dp_sel    = display_dp[k];
        blank_sel = blank[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      idx          <= '0;
      shadow_val   <= '0;
      shadow_dp    <= '0;
      display_val  <= '0;
      display_dp   <= '0;
      pending_r    <= 1'b0;
      frame_tick_r <= 1'b0;
      an_r         <= '1;
      seg_r        <= 7'h7F;
      dp_r         <= 1'b1;
    end else begin
      frame_tick_r <= wrap;

      if (step) begin
        presc <= '0;
        idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else if (en) begin
        presc <= presc + 1'b1;
      end

      // Display takes the old shadow at the wrap; a load on that same edge waits a frame.
      if (wrap && pending_r) begin
        display_val <= shadow_val;
        display_dp  <= shadow_dp;
      end

      if (bus.load) begin
        shadow_val <= bus.value_in;
        shadow_dp  <= bus.dp_in;
        pending_r  <= 1'b1;
      end else if (wrap) begin
        pending_r  <= 1'b0;
      end

      if (!en) begin
        an_r  <= '1;
        seg_r <= 7'h7F;
        dp_r  <= 1'b1;
      end else begin
        // Anodes go dark for the cycle the index moves to avoid ghosting.
        an_r  <= step ? '1 : ~(DIGITS'(1) << idx);
        seg_r <= blank_sel ? 7'h7F : ~hex_pattern(nib);
        dp_r  <= ~dp_sel;
      end
    end
  end

  assign bus.an         = an_r;
  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.frame_tick = frame_tick_r;
  assign bus.pending    = pending_r;
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb/tb_sevenseg_scan.sv - scoreboard bench for sevenseg_scan with DIGITS=4, PRESCALE=4
module tb_sevenseg_scan;
  localparam int D = 4;
  localparam int P = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  logic  en    = 1'b0;
  int    tests = 0;
  int    fails = 0;
  disp_t sb[$];

  sevenseg_scan_if #(.DIGITS(D)) bus();

  sevenseg_scan #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_on(input logic [3:0] n);
    case (n)
      4'h0: seg_on = 7'h3F;  4'h1: seg_on = 7'h06;  4'h2: seg_on = 7'h5B;  4'h3: seg_on = 7'h4F;
      4'h4: seg_on = 7'h66;  4'h5: seg_on = 7'h6D;  4'h6: seg_on = 7'h7D;  4'h7: seg_on = 7'h07;
      4'h8: seg_on = 7'h7F;  4'h9: seg_on = 7'h6F;  4'hA: seg_on = 7'h77;  4'hB: seg_on = 7'h7C;
      4'hC: seg_on = 7'h39;  4'hD: seg_on = 7'h5E;  4'hE: seg_on = 7'h79;  default: seg_on = 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bus.value_in = v;
    bus.dp_in    = d;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
    logic [3:0] blank;
    disp_t      e;
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic zr;
      zr = 1'b1;
      for (int k = D - 1; k > 0; k--) begin
        zr       = zr && (v[4*k +: 4] == 4'h0);
        blank[k] = zr;
      end
    end
`endif
    for (int k = 0; k < D; k++) begin
      e.an  = ~(4'b0001 << k);
      e.seg = blank[k] ? 7'h7F : ~seg_on(v[4*k +: 4]);
      e.dp  = ~d[k];
      sb.push_back(e);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.frame_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("frame_tick_seen", 32'(bus.frame_tick), 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (bus.an !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.an), 32'(target));
  endtask

  // Pops one expectation each time a new digit lights up.
  task automatic check_frame(input string tag);
    logic [3:0] prev;
    disp_t      got, want;
    int         n;
    prev = 4'hF;
    n    = 0;
    while (sb.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.an !== prev && bus.an !== 4'hF) begin
        got  = {bus.an, bus.seg, bus.dp};
        want = sb.pop_front();
        chk(tag, 32'(got), 32'(want));
      end
      prev = bus.an;
    end
    chk({tag, "_timeout"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ea;
    bus.load     = 1'b0;
    bus.value_in = '0;
    bus.dp_in    = '0;
    cycles(2);
    chk("rst_an",   32'(bus.an), 32'hF);
    chk("rst_seg",  32'(bus.seg), 32'h7F);
    chk("rst_dp",   32'(bus.dp), 32'd1);
    chk("rst_tick", 32'(bus.frame_tick), 32'd0);
    chk("rst_pend", 32'(bus.pending), 32'd0);

    en    = 1'b1;
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      ea = (k % 4 == 0) ? 4'hF : ~(4'b0001 << (k / 4));
      chk("scan_an", 32'(bus.an), 32'(ea));
      chk("scan_tick", 32'(bus.frame_tick), 32'(k == 16));
    end
    push_frame(16'h0000, 4'h0);
    check_frame("zero_frame");

    wait_tick();
    cycles(5);
    do_load(16'h12AF, 4'h0);
    chk("load_pending", 32'(bus.pending), 32'd1);
    wait_an(4'b0111, "old_digit3_an");
    chk("old_digit3_seg", 32'(bus.seg), 32'h40);
    push_frame(16'h12AF, 4'h0);
    wait_tick();
    check_frame("frame_12af");
    chk("pending_cleared", 32'(bus.pending), 32'd0);

    wait_tick();
    cycles(2);
    do_load(16'h1111, 4'h0);
    do_load(16'h2222, 4'h0);
    push_frame(16'h2222, 4'h0);
    wait_tick();
    check_frame("last_load_wins");

    wait_tick();
    cycles(15);
    do_load(16'h0F3C, 4'b0100);
    chk("wrap_tick", 32'(bus.frame_tick), 32'd1);
    chk("wrap_pending", 32'(bus.pending), 32'd1);
    push_frame(16'h2222, 4'h0);
    check_frame("wrap_load_deferred");
    push_frame(16'h0F3C, 4'b0100);
    wait_tick();
    check_frame("wrap_load_applied");

    wait_tick();
    cycles(2);
    chk("pre_pause_an", 32'(bus.an), 32'hE);
    en = 1'b0;
    do_load(16'h0042, 4'h0);
    chk("pause_an", 32'(bus.an), 32'hF);
    chk("pause_seg", 32'(bus.seg), 32'h7F);
    chk("pause_dp", 32'(bus.dp), 32'd1);
    chk("pause_pending", 32'(bus.pending), 32'd1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("pause_dark", 32'({bus.an, bus.frame_tick}), 32'h1E);
    end
    en = 1'b1;
    @(negedge clk);
    chk("resume_same_digit", 32'(bus.an), 32'hE);
    @(negedge clk);
    chk("resume_ghost", 32'(bus.an), 32'hF);
    @(negedge clk);
    chk("resume_next_digit", 32'(bus.an), 32'hD);
    push_frame(16'h0042, 4'h0);
    wait_tick();
    check_frame("frame_0042");

    do_load(16'h0000, 4'h0);
    push_frame(16'h0000, 4'h0);
    wait_tick();
    check_frame("frame_0000");

    do_load(16'h5555, 4'hF);
    chk("pre_reset_pending", 32'(bus.pending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", 32'(bus.an), 32'hF);
    chk("async_rst_seg", 32'(bus.seg), 32'h7F);
    chk("async_rst_dp", 32'(bus.dp), 32'd1);
    chk("async_rst_pending", 32'(bus.pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(16'h0000, 4'h0);
    wait_tick();
    check_frame("post_reset_frame");
    chk("post_reset_pending", 32'(bus.pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
